// File: rtl/instr_mem_ctrl.sv
`default_nettype none
// =====================================================================
// Module  : instr_mem_ctrl
// Brief   : fetch-stage instruction memory, req/ack fetch with fixed
//           RD_LAT latency, held response and side load port.
//           Define IMEM_PARITY_EN to add per-word even parity.
// Revision: 1.0
// =====================================================================
module instr_mem_ctrl #(
  parameter int              DW        = 32,
  parameter int              AW        = 32,
  parameter int              DEPTH     = 40,
  parameter int              RD_LAT    = 2,
  parameter logic [DW-1:0]   NOP_WORD  = 32'h38800000,
  parameter string           INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          fetch_req,
  input  logic [AW-1:0] fetch_addr,
  output logic          fetch_ack,
  output logic          instr_valid,
  output logic [DW-1:0] instr,
  output logic          fetch_err,
  input  logic          instr_ready,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] load_data,
`ifdef IMEM_PARITY_EN
  input  logic          force_par_flip,
  output logic          parity_err,
`endif
  output logic          busy
);

  localparam int              c_iw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              c_cw    = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
  localparam logic [AW-3:0]   c_depth = (AW-2)'(DEPTH);
  localparam logic [c_cw-1:0] c_last  = c_cw'((RD_LAT > 1) ? RD_LAT - 2 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t          state_q;
  logic [c_cw-1:0] cnt_q;
  logic [AW-1:0]   addr_q;
  logic            valid_q;
  logic [DW-1:0]   instr_q;
  logic            err_q;

  logic [DW-1:0]   mem_q [DEPTH];

  logic [AW-1:0]   rd_addr;
  logic            rd_ok;
  logic [c_iw-1:0] rd_idx;
  logic            ld_ok;
  logic [c_iw-1:0] ld_idx;
  logic [DW-1:0]   instr_d;
  logic            err_d;

  // The HOLD-entry read comes straight from fetch_addr when RD_LAT=1.
  assign rd_addr = (state_q == S_IDLE) ? fetch_addr : addr_q;
  assign rd_ok   = (rd_addr[1:0] == 2'b00) && (rd_addr[AW-1:2] < c_depth);
  assign rd_idx  = rd_addr[c_iw+1:2];
  assign ld_ok   = (load_addr[1:0] == 2'b00) && (load_addr[AW-1:2] < c_depth);
  assign ld_idx  = load_addr[c_iw+1:2];

`ifdef IMEM_PARITY_EN
  logic par_q [DEPTH];
  logic perr_q;
  logic perr_d;

  always_comb begin
    perr_d  = rd_ok && (par_q[rd_idx] != ^mem_q[rd_idx]);
    instr_d = NOP_WORD;
    err_d   = 1'b1;
    if (rd_ok && !perr_d) begin
      instr_d = mem_q[rd_idx];
      err_d   = 1'b0;
    end
  end

  assign parity_err = perr_q & valid_q;
`else
  always_comb begin
    instr_d = NOP_WORD;
    err_d   = 1'b1;
    if (rd_ok) begin
      instr_d = mem_q[rd_idx];
      err_d   = 1'b0;
    end
  end
`endif

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] = NOP_WORD;
`ifdef IMEM_PARITY_EN
    for (int i = 0; i < DEPTH; i++) par_q[i] = ^mem_q[i];
`endif
  end

  // Contents survive reset; only writes are suppressed while it is asserted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (reset_n && load_en && ld_ok) begin
      mem_q[ld_idx] <= load_data;
`ifdef IMEM_PARITY_EN
      par_q[ld_idx] <= (^load_data) ^ force_par_flip;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      instr_q <= '0;
      err_q   <= 1'b0;
`ifdef IMEM_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (fetch_req) begin
            addr_q <= fetch_addr;
            cnt_q  <= '0;
            if (RD_LAT == 1) begin
              state_q <= S_HOLD;
              valid_q <= 1'b1;
              instr_q <= instr_d;
              err_q   <= err_d;
`ifdef IMEM_PARITY_EN
              perr_q  <= perr_d;
`endif
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == c_last) begin
            state_q <= S_HOLD;
            valid_q <= 1'b1;
            instr_q <= instr_d;
            err_q   <= err_d;
`ifdef IMEM_PARITY_EN
            perr_q  <= perr_d;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fetch_ack   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign fetch_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_ctrl.sv
`default_nettype none
// Self-checking bench for instr_mem_ctrl: transaction-level reference model
// compared every cycle, plus directed literal checks and random traffic.
module tb_instr_mem_ctrl;
  parameter int RD_LAT = 2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int DEPTH = 40;
  localparam logic [31:0] NOP = 32'h38800000;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_ack;
  logic          instr_valid;
  logic [DW-1:0] instr;
  logic          fetch_err;
  logic          instr_ready;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic          busy;
`ifdef IMEM_PARITY_EN
  logic          force_par_flip;
  logic          parity_err;
  logic          last_perr;
`endif

  instr_mem_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset_n(reset_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .instr_valid(instr_valid), .instr(instr), .fetch_err(fetch_err),
    .instr_ready(instr_ready), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
`ifdef IMEM_PARITY_EN
    .force_par_flip(force_par_flip), .parity_err(parity_err),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [31:0] m_mem [DEPTH];
  bit          m_flip [DEPTH];
  bit          m_busy, m_valid, m_err, m_perr, m_took;
  logic [31:0] m_instr, m_addr;
  longint      cyc = 0;
  longint      m_due;

  function automatic bit legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ((a >> 2) < DEPTH);
  endfunction

  task automatic model_step();
    bit          fl;
    logic [31:0] ix;
`ifdef IMEM_PARITY_EN
    fl = force_par_flip;
`else
    fl = 1'b0;
`endif
    m_took = 1'b0;
    if (!reset_n) begin
      m_busy = 0; m_valid = 0; m_err = 0; m_perr = 0; m_instr = '0;
      return;
    end
    if (m_valid) begin
      if (instr_ready) begin m_valid = 0; m_busy = 0; end
    end else begin
      if (!m_busy && fetch_req) begin
        m_busy = 1; m_took = 1; m_addr = fetch_addr;
        m_due = cyc + RD_LAT - 1;
      end
      if (m_busy && cyc == m_due) begin
        ix = m_addr >> 2;
        if (legal(m_addr) && !m_flip[ix]) begin
          m_instr = m_mem[ix]; m_err = 0; m_perr = 0;
        end else begin
          m_instr = NOP; m_err = 1; m_perr = legal(m_addr);
        end
        m_valid = 1;
      end
    end
    if (load_en && legal(load_addr)) begin
      ix = load_addr >> 2;
      m_mem[ix]  = load_data;
      m_flip[ix] = fl;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    chk("fetch_ack", {31'b0, fetch_ack}, {31'b0, !m_busy});
    chk("busy", {31'b0, busy}, {31'b0, m_busy});
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
    chk("instr", instr, m_instr);
    chk("fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
`ifdef IMEM_PARITY_EN
    chk("parity_err", {31'b0, parity_err}, {31'b0, m_valid && m_perr});
`endif
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6)       return 32'($urandom_range(0, DEPTH-1)) << 2;
    else if (r == 6) return (32'($urandom_range(0, DEPTH-1)) << 2) | 32'($urandom_range(1, 3));
    else if (r == 7) return 32'(DEPTH*4) + (32'($urandom_range(0, 7)) << 2);
    else if (r == 8) return $urandom;
    else             return 32'((DEPTH-1)*4);
  endfunction

  task automatic do_load(input logic [31:0] a, input logic [31:0] d, input bit flip);
    load_en = 1; load_addr = a; load_data = d;
`ifdef IMEM_PARITY_EN
    force_par_flip = flip;
`endif
    @(negedge clk); #1;
    load_en = 0;
`ifdef IMEM_PARITY_EN
    force_par_flip = 0;
`else
    if (flip) $display("note: parity flip requested without parity build");
`endif
  endtask

  // Issues a fetch from idle with ready=1; optional load to the same word timed
  // to land on the HOLD-entry edge. lat counts edges from accept to valid.
  task automatic do_fetch(input logic [31:0] a, input bit col, input logic [31:0] ld,
                          output logic [31:0] w, output logic e, output int lat);
    w = '0; e = 1'b0; lat = -1;
    fetch_req = 1; fetch_addr = a; instr_ready = 1;
    for (int k = 0; k < 32; k++) begin
      if (col && k == RD_LAT-1) begin load_en = 1; load_addr = a; load_data = ld; end
      @(negedge clk);
      if (instr_valid) begin
        w = instr; e = fetch_err; lat = k + 1;
`ifdef IMEM_PARITY_EN
        last_perr = parity_err;
`endif
        break;
      end
      #1; fetch_req = 0; load_en = 0;
    end
    #1; fetch_req = 0; load_en = 0;
    @(negedge clk); #1;
  endtask

  logic [31:0] w;
  logic        e;
  int          lat;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin m_mem[i] = NOP; m_flip[i] = 0; end
    reset_n = 0; fetch_req = 0; fetch_addr = '0; instr_ready = 1;
    load_en = 0; load_addr = '0; load_data = '0;
`ifdef IMEM_PARITY_EN
    force_par_flip = 0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_ack", {31'b0, fetch_ack}, 32'd1);
    #1; reset_n = 1;
    @(negedge clk); #1;

    // Reset while a fetch is in flight abandons it.
    fetch_req = 1; fetch_addr = 0;
    @(negedge clk); #1;
    fetch_req = 0; reset_n = 0;
    @(negedge clk);
    chk("midrst_valid", {31'b0, instr_valid}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_ack", {31'b0, fetch_ack}, 32'd1);
    #1; reset_n = 1;
    @(negedge clk); #1;
    do_fetch(32'h0, 0, 0, w, e, lat);
    chk("post_rst_word", w, NOP);
    chk("post_rst_err", {31'b0, e}, 32'd0);
    chk("post_rst_lat", 32'(lat), 32'(RD_LAT));

    // Load then fetch.
    do_load(32'h0, 32'h58000000, 0);
    do_load(32'h4, 32'h58080003, 0);
    do_fetch(32'h0, 0, 0, w, e, lat);
    chk("word0", w, 32'h58000000);
    chk("word0_err", {31'b0, e}, 32'd0);
    chk("word0_lat", 32'(lat), 32'(RD_LAT));
    do_fetch(32'h4, 0, 0, w, e, lat);
    chk("word1", w, 32'h58080003);

    // Address errors, and the last legal word.
    do_fetch(32'h2, 0, 0, w, e, lat);
    chk("misalign_word", w, NOP);
    chk("misalign_err", {31'b0, e}, 32'd1);
    chk("misalign_lat", 32'(lat), 32'(RD_LAT));
    do_fetch(32'd160, 0, 0, w, e, lat);
    chk("range_word", w, NOP);
    chk("range_err", {31'b0, e}, 32'd1);
    chk("range_lat", 32'(lat), 32'(RD_LAT));
    do_load(32'd156, 32'hABCD0156, 0);
    do_fetch(32'd156, 0, 0, w, e, lat);
    chk("last_word", w, 32'hABCD0156);
    chk("last_err", {31'b0, e}, 32'd0);

    // Backpressure in HOLD.
    do_load(32'h8, 32'h5A5A0008, 0);
    fetch_req = 1; fetch_addr = 32'h8; instr_ready = 0;
    @(negedge clk); #1;
    fetch_addr = 32'h10;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (instr_valid) break;
      #1;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_instr", instr, 32'h5A5A0008);
      chk("bp_ack", {31'b0, fetch_ack}, 32'd0);
      chk("bp_valid", {31'b0, instr_valid}, 32'd1);
      @(negedge clk);
    end
    #1; instr_ready = 1; fetch_req = 0;
    @(negedge clk);
    chk("bp_release_valid", {31'b0, instr_valid}, 32'd0);
    chk("bp_release_ack", {31'b0, fetch_ack}, 32'd1);
    #1;

    // Read-before-write collision on word 8.
    do_load(32'h8, 32'h11110008, 0);
    do_fetch(32'h8, 1, 32'h22220008, w, e, lat);
    chk("collide_old", w, 32'h11110008);
    do_fetch(32'h8, 0, 0, w, e, lat);
    chk("collide_new", w, 32'h22220008);

`ifdef IMEM_PARITY_EN
    do_load(32'd12, 32'h0000000C, 1);
    do_fetch(32'd12, 0, 0, w, e, lat);
    chk("par_word", w, NOP);
    chk("par_err", {31'b0, e}, 32'd1);
    chk("par_flag", {31'b0, last_perr}, 32'd1);
    chk("par_lat", 32'(lat), 32'(RD_LAT));
`endif

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk); #1;
      if (!(fetch_req && !m_took)) begin
        fetch_req  = ($urandom_range(0, 2) == 0);
        fetch_addr = rand_addr();
      end
      instr_ready = ($urandom_range(0, 9) < 7);
      load_en     = ($urandom_range(0, 3) == 0);
      load_addr   = rand_addr();
      load_data   = $urandom;
`ifdef IMEM_PARITY_EN
      force_par_flip = ($urandom_range(0, 7) == 0);
`endif
      reset_n = ($urandom_range(0, 199) != 0);
    end
    @(negedge clk); #1;
    reset_n = 1; fetch_req = 0; load_en = 0; instr_ready = 1;
    repeat (RD_LAT + 4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
